// File: rtl/alu_pkg.sv
// Shared constants for the format-I execute stage: opcodes, ALU function
// selects, status-register bit positions and the sequencer state encoding.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FS_W   = 6;

  // Format-I opcodes
  localparam logic [3:0] OPC_MOV  = 4'h4;
  localparam logic [3:0] OPC_ADD  = 4'h5;
  localparam logic [3:0] OPC_ADDC = 4'h6;
  localparam logic [3:0] OPC_SUBC = 4'h7;
  localparam logic [3:0] OPC_SUB  = 4'h8;
  localparam logic [3:0] OPC_CMP  = 4'h9;
  localparam logic [3:0] OPC_DADD = 4'hA;
  localparam logic [3:0] OPC_BIT  = 4'hB;
  localparam logic [3:0] OPC_BIC  = 4'hC;
  localparam logic [3:0] OPC_BIS  = 4'hD;
  localparam logic [3:0] OPC_XOR  = 4'hE;
  localparam logic [3:0] OPC_AND  = 4'hF;

  // ALU function selects, shared with the ALU
  localparam logic [FS_W-1:0] FS_ADD  = 6'h00;
  localparam logic [FS_W-1:0] FS_ADDC = 6'h01;
  localparam logic [FS_W-1:0] FS_SUBC = 6'h02;
  localparam logic [FS_W-1:0] FS_SUB  = 6'h03;
  localparam logic [FS_W-1:0] FS_MOV  = 6'h10;
  localparam logic [FS_W-1:0] FS_AND  = 6'h11;
  localparam logic [FS_W-1:0] FS_BIC  = 6'h12;
  localparam logic [FS_W-1:0] FS_BIS  = 6'h13;
  localparam logic [FS_W-1:0] FS_XOR  = 6'h14;

  // Status register bit positions
  localparam int unsigned SR_C = 0;
  localparam int unsigned SR_Z = 1;
  localparam int unsigned SR_N = 2;
  localparam int unsigned SR_V = 8;

  // Bit positions inside the ALU flag vector {C,V,N,Z}
  localparam int unsigned CVNZ_C = 3;
  localparam int unsigned CVNZ_V = 2;
  localparam int unsigned CVNZ_N = 1;
  localparam int unsigned CVNZ_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_MWAIT = 2'd3
  } state_e;

  // Opcodes this stage can execute (DADD and non-format-I codes are rejected)
  function automatic logic opc_legal(input logic [3:0] opc);
    return (opc >= OPC_MOV) && (opc != OPC_DADD);
  endfunction

  // Opcode to ALU function select; CMP reuses SUB, BIT reuses AND
  function automatic logic [FS_W-1:0] opc_to_fs(input logic [3:0] opc);
    logic [FS_W-1:0] fs;
    case (opc)
      OPC_ADD:          fs = FS_ADD;
      OPC_ADDC:         fs = FS_ADDC;
      OPC_SUBC:         fs = FS_SUBC;
      OPC_SUB, OPC_CMP: fs = FS_SUB;
      OPC_AND, OPC_BIT: fs = FS_AND;
      OPC_BIC:          fs = FS_BIC;
      OPC_BIS:          fs = FS_BIS;
      OPC_XOR:          fs = FS_XOR;
      default:          fs = FS_MOV;
    endcase
    return fs;
  endfunction

endpackage

// File: rtl/alu_flag_map.sv
// Combinational mapping of opcode and ALU flags onto the new status register.
module alu_flag_map
  import alu_pkg::*;
#(
  parameter int unsigned SIZE = DATA_W
) (
  input  logic [3:0]      opc_i,
  input  logic            bw_i,
  input  logic [SIZE-1:0] src_i,
  input  logic [SIZE-1:0] dst_i,
  input  logic [SIZE-1:0] sr_i,
  input  logic [3:0]      cvnz_i,
  output logic            sr_we_c_o,
  output logic [SIZE-1:0] sr_wdata_c_o
);

  localparam int unsigned HALF = SIZE / 2;

  logic src_msb;
  logic dst_msb;

  // Select flag sources per opcode; non-flag SR bits pass through
  always_comb begin
    src_msb      = bw_i ? src_i[HALF-1] : src_i[SIZE-1];
    dst_msb      = bw_i ? dst_i[HALF-1] : dst_i[SIZE-1];
    sr_we_c_o    = 1'b0;
    sr_wdata_c_o = sr_i;
    case (opc_i)
      OPC_ADD, OPC_ADDC, OPC_SUBC, OPC_SUB, OPC_CMP: begin
        sr_we_c_o          = 1'b1;
        sr_wdata_c_o[SR_C] = cvnz_i[CVNZ_C];
        sr_wdata_c_o[SR_V] = cvnz_i[CVNZ_V];
        sr_wdata_c_o[SR_N] = cvnz_i[CVNZ_N];
        sr_wdata_c_o[SR_Z] = cvnz_i[CVNZ_Z];
      end
      OPC_AND, OPC_BIT: begin
        sr_we_c_o          = 1'b1;
        sr_wdata_c_o[SR_C] = ~cvnz_i[CVNZ_Z];
        sr_wdata_c_o[SR_V] = 1'b0;
        sr_wdata_c_o[SR_N] = cvnz_i[CVNZ_N];
        sr_wdata_c_o[SR_Z] = cvnz_i[CVNZ_Z];
      end
      OPC_XOR: begin
        sr_we_c_o          = 1'b1;
        sr_wdata_c_o[SR_C] = ~cvnz_i[CVNZ_Z];
        sr_wdata_c_o[SR_V] = src_msb & dst_msb;
        sr_wdata_c_o[SR_N] = cvnz_i[CVNZ_N];
        sr_wdata_c_o[SR_Z] = cvnz_i[CVNZ_Z];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for format-I instructions: drives the ALU, then
// writes the result to the register file or memory and the flags to SR.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SIZE = DATA_W
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [3:0]      REQ_OPC,
  input  logic            REQ_BW,
  input  logic [SIZE-1:0] REQ_SRC,
  input  logic [SIZE-1:0] REQ_DST,
  input  logic [3:0]      REQ_DREG,
  input  logic            REQ_DMEM,
  input  logic [SIZE-1:0] SR_IN,
  output logic [SIZE-1:0] ALU_SRC,
  output logic [SIZE-1:0] ALU_DST,
  output logic            ALU_BW,
  output logic            ALU_CIN,
  output logic [5:0]      ALU_FS,
  input  logic [SIZE-1:0] ALU_RES,
  input  logic [3:0]      ALU_CVNZ,
  output logic            RF_WE,
  output logic [3:0]      RF_WADDR,
  output logic [SIZE-1:0] RF_WDATA,
  output logic            SR_WE,
  output logic [SIZE-1:0] SR_WDATA,
  output logic            MEM_WR_VALID,
  input  logic            MEM_WR_READY,
  output logic [SIZE-1:0] MEM_WR_DATA,
  output logic            MEM_WR_BYTE,
  output logic            DONE,
  output logic            ERR
);

  localparam int unsigned HALF = SIZE / 2;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic [SIZE-1:0] alu_src_q, alu_src_d;
  logic [SIZE-1:0] alu_dst_q, alu_dst_d;
  logic            alu_bw_q, alu_bw_d;
  logic            alu_cin_q, alu_cin_d;
  logic [FS_W-1:0] alu_fs_q, alu_fs_d;
  logic [3:0]      opc_q, opc_d;
  logic [3:0]      dreg_q, dreg_d;
  logic            dmem_q, dmem_d;
  logic [SIZE-1:0] sr_q, sr_d;
  logic            rf_we_q, rf_we_d;
  logic [3:0]      rf_waddr_q, rf_waddr_d;
  logic [SIZE-1:0] rf_wdata_q, rf_wdata_d;
  logic            sr_we_q, sr_we_d;
  logic [SIZE-1:0] sr_wdata_q, sr_wdata_d;
  logic            mem_valid_q, mem_valid_d;
  logic [SIZE-1:0] mem_data_q, mem_data_d;
  logic            mem_byte_q, mem_byte_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            flag_we_c;
  logic [SIZE-1:0] flag_sr_c;
  logic [SIZE-1:0] wb_data_c;
  logic            flags_only_c;

  alu_flag_map #(.SIZE(SIZE)) u_flag_map (
    .opc_i        (opc_q),
    .bw_i         (alu_bw_q),
    .src_i        (alu_src_q),
    .dst_i        (alu_dst_q),
    .sr_i         (sr_q),
    .cvnz_i       (ALU_CVNZ),
    .sr_we_c_o    (flag_we_c),
    .sr_wdata_c_o (flag_sr_c)
  );

  // Byte results are zero-extended; CMP and BIT never write a destination
  assign wb_data_c    = alu_bw_q ? {{(SIZE-HALF){1'b0}}, ALU_RES[HALF-1:0]} : ALU_RES;
  assign flags_only_c = (opc_q == OPC_CMP) || (opc_q == OPC_BIT);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    alu_src_d   = alu_src_q;
    alu_dst_d   = alu_dst_q;
    alu_bw_d    = alu_bw_q;
    alu_cin_d   = alu_cin_q;
    alu_fs_d    = alu_fs_q;
    opc_d       = opc_q;
    dreg_d      = dreg_q;
    dmem_d      = dmem_q;
    sr_d        = sr_q;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    sr_wdata_d  = sr_wdata_q;
    mem_valid_d = mem_valid_q;
    mem_data_d  = mem_data_q;
    mem_byte_d  = mem_byte_q;
    rf_we_d     = 1'b0;
    sr_we_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID && ready_q) begin
          if (opc_legal(REQ_OPC)) begin
            alu_src_d = REQ_SRC;
            alu_dst_d = REQ_DST;
            alu_bw_d  = REQ_BW;
            alu_cin_d = SR_IN[SR_C];
            alu_fs_d  = opc_to_fs(REQ_OPC);
            opc_d     = REQ_OPC;
            dreg_d    = REQ_DREG;
            dmem_d    = REQ_DMEM;
            sr_d      = SR_IN;
            state_d   = ST_EXEC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        state_d    = ST_WB;
        sr_we_d    = flag_we_c;
        sr_wdata_d = flag_sr_c;
        if (flags_only_c) begin
          done_d = 1'b1;
        end else if (dmem_q) begin
          mem_valid_d = 1'b1;
          mem_data_d  = wb_data_c;
          mem_byte_d  = alu_bw_q;
        end else begin
          rf_we_d    = 1'b1;
          rf_waddr_d = dreg_q;
          rf_wdata_d = wb_data_c;
          done_d     = 1'b1;
        end
      end
      ST_WB: begin
        if (mem_valid_q && !MEM_WR_READY) begin
          state_d = ST_MWAIT;
        end else begin
          mem_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_MWAIT: begin
        if (MEM_WR_READY) begin
          mem_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      alu_src_q   <= '0;
      alu_dst_q   <= '0;
      alu_bw_q    <= 1'b0;
      alu_cin_q   <= 1'b0;
      alu_fs_q    <= '0;
      opc_q       <= '0;
      dreg_q      <= '0;
      dmem_q      <= 1'b0;
      sr_q        <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      sr_we_q     <= 1'b0;
      sr_wdata_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_data_q  <= '0;
      mem_byte_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      alu_src_q   <= alu_src_d;
      alu_dst_q   <= alu_dst_d;
      alu_bw_q    <= alu_bw_d;
      alu_cin_q   <= alu_cin_d;
      alu_fs_q    <= alu_fs_d;
      opc_q       <= opc_d;
      dreg_q      <= dreg_d;
      dmem_q      <= dmem_d;
      sr_q        <= sr_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      sr_we_q     <= sr_we_d;
      sr_wdata_q  <= sr_wdata_d;
      mem_valid_q <= mem_valid_d;
      mem_data_q  <= mem_data_d;
      mem_byte_q  <= mem_byte_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign REQ_READY    = ready_q;
  assign ALU_SRC      = alu_src_q;
  assign ALU_DST      = alu_dst_q;
  assign ALU_BW       = alu_bw_q;
  assign ALU_CIN      = alu_cin_q;
  assign ALU_FS       = alu_fs_q;
  assign RF_WE        = rf_we_q;
  assign RF_WADDR     = rf_waddr_q;
  assign RF_WDATA     = rf_wdata_q;
  assign SR_WE        = sr_we_q;
  assign SR_WDATA     = sr_wdata_q;
  assign MEM_WR_VALID = mem_valid_q;
  assign MEM_WR_DATA  = mem_data_q;
  assign MEM_WR_BYTE  = mem_byte_q;
  assign ERR          = err_q;
  // Memory retirement must coincide with the handshake cycle itself
  assign DONE         = done_q | (mem_valid_q & MEM_WR_READY);

endmodule
